// File: rtl/rx_frame_filter_fifo.sv
// rx_frame_filter_fifo
//   Qualifies each frame from rx_receiver by CRC status and destination ID,
//   queues accepted frames (src_id + 128-bit payload) in a DEPTH-slot FIFO,
//   and replays the head frame as a byte stream (MSB byte first) with a
//   valid/ready handshake. Per-cause saturating drop/accept counters are kept.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   my_id             : local node ID
//   dest_id, src_id   : frame header fields from rx_receiver
//   payload           : frame payload, byte 15 = [127:120]
//   frame_valid       : frame-complete strobe (rising edge = one frame event)
//   crc_error         : CRC failure flag, qualified by frame_valid
//   out_valid/ready   : byte stream handshake
//   out_data, out_src : current byte and src_id of the frame being streamed
//   out_sop, out_eop  : first / last byte markers
//   fifo_count        : frames currently queued
//   *_cnt             : saturating statistics counters
module rx_frame_filter_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               my_id,
    input  logic [1:0]               dest_id,
    input  logic [1:0]               src_id,
    input  logic [127:0]             payload,
    input  logic                     frame_valid,
    input  logic                     crc_error,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [1:0]               out_src,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         good_cnt,
    output logic [CNT_W-1:0]         crc_drop_cnt,
    output logic [CNT_W-1:0]         addr_drop_cnt,
    output logic [CNT_W-1:0]         ovf_drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]   src;
        logic [127:0] data;
    } frame_t;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    // counter slots: 0 good, 1 crc drop, 2 addr drop, 3 overflow drop
    localparam int NUM_CNT = 4;

    frame_t                         mem [DEPTH];
    frame_t                         head;
    logic [AW-1:0]                  wr_ptr, rd_ptr;
    logic [AW:0]                    count, count_nxt;
    logic                           fv_q, evt, push, pop, full, send;
    logic                           id_match;
    state_t                         state, state_nxt;
    logic [3:0]                     idx, idx_nxt;
    logic [NUM_CNT-1:0]             inc;
    logic [NUM_CNT-1:0][CNT_W-1:0]  cnt_q;

    assign evt      = frame_valid & ~fv_q;
    assign id_match = (dest_id == my_id);
    // Outputs are forced idle while rst is asserted, not just after the edge.
    assign send     = (state == S_SEND) & ~rst;
    assign pop      = send & out_ready & (idx == 4'd15);
    // A same-cycle pop frees the slot, so a full FIFO still accepts then.
    assign full     = (count == (AW+1)'(DEPTH)) & ~pop;
    assign push     = evt & ~crc_error & id_match & ~full;

    assign inc[0] = push;
    assign inc[1] = evt & crc_error;
    assign inc[2] = evt & ~crc_error & ~id_match;
    assign inc[3] = evt & ~crc_error & id_match & full;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Frame edge detect and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            fv_q   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            fv_q  <= frame_valid;
            count <= count_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When full with a same-cycle pop, wr_ptr == rd_ptr: the write lands on
    // the slot being retired, whose last byte is already on out_data.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {src_id, payload};
    end

    assign head = mem[rd_ptr];

    // Output stream FSM
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: if (count != '0) state_nxt = S_SEND;
            S_SEND: begin
                if (send && out_ready) begin
                    if (idx == 4'd15) begin
                        idx_nxt = 4'd0;
                        if (count_nxt == '0) state_nxt = S_IDLE;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= 4'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // ~idx == 15-idx selects the byte, MSB byte first
    assign out_valid  = send;
    assign out_data   = send ? head.data[{~idx, 3'b000} +: 8] : 8'h00;
    assign out_src    = send ? head.src : 2'b00;
    assign out_sop    = send & (idx == 4'd0);
    assign out_eop    = send & (idx == 4'd15);
    assign fifo_count = rst ? '0 : count;

    // Saturating statistics counters
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst)
                cnt_q[g] <= '0;
            else if (inc[g] && (cnt_q[g] != {CNT_W{1'b1}}))
                cnt_q[g] <= cnt_q[g] + 1'b1;
        end
    end

    assign good_cnt      = cnt_q[0];
    assign crc_drop_cnt  = cnt_q[1];
    assign addr_drop_cnt = cnt_q[2];
    assign ovf_drop_cnt  = cnt_q[3];

endmodule

// File: tb/tb_rx_frame_filter_fifo.sv
// tb_rx_frame_filter_fifo
//   Directed bench for rx_frame_filter_fifo (DEPTH=4, CNT_W=8). Inputs are
//   driven and outputs sampled 1 time unit after each rising clock edge.
module tb_rx_frame_filter_fifo;

    localparam int C_GOOD = 0, C_CRC = 1, C_ADDR = 2, C_OVF = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   my_id, dest_id, src_id;
    logic [127:0] payload;
    logic         frame_valid, crc_error;
    logic         out_valid, out_ready;
    logic [7:0]   out_data;
    logic [1:0]   out_src;
    logic         out_sop, out_eop;
    logic [2:0]   fifo_count;
    logic [7:0]   good_cnt, crc_drop_cnt, addr_drop_cnt, ovf_drop_cnt;

    int total = 0;
    int bad   = 0;

    rx_frame_filter_fifo #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .my_id(my_id), .dest_id(dest_id), .src_id(src_id),
        .payload(payload), .frame_valid(frame_valid), .crc_error(crc_error),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_sop(out_sop), .out_eop(out_eop),
        .fifo_count(fifo_count), .good_cnt(good_cnt), .crc_drop_cnt(crc_drop_cnt),
        .addr_drop_cnt(addr_drop_cnt), .ovf_drop_cnt(ovf_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         crc;
        logic [1:0]   my;
        logic [1:0]   dest;
        logic [1:0]   src;
        logic [127:0] pl;
        int           cause;
    } vec_t;

    vec_t tbl [10];

    localparam logic [127:0] P0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] P1 = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    localparam logic [127:0] P2 = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    localparam logic [127:0] P3 = 128'h0F0F0F0F_A5A5A5A5_5A5A5A5A_F0F0F0F0;
    localparam logic [127:0] P4 = 128'h13579BDF_2468ACE0_C0FFEE00_BADC0DE5;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] p, input int k);
        return p[8*(15-k) +: 8];
    endfunction

    // {valid, sop, eop, src, data}
    function automatic logic [12:0] exp_out(input logic [1:0] s, input logic [127:0] p, input int k);
        return {1'b1, (k == 0), (k == 15), s, byte_of(p, k)};
    endfunction

    function automatic logic [12:0] act_out();
        return {out_valid, out_sop, out_eop, out_src, out_data};
    endfunction

    task automatic set_frame(input logic crc, input logic [1:0] my, input logic [1:0] dest,
                             input logic [1:0] src, input logic [127:0] pl);
        crc_error = crc; my_id = my; dest_id = dest; src_id = src; payload = pl;
    endtask

    // One-cycle frame_valid pulse; returns just after the event edge.
    task automatic pulse();
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Expects out_ready=1 and the frame at idx 0; consumes 16 bytes.
    task automatic drain_frame(input string nm, input logic [1:0] s, input logic [127:0] p);
        for (int k = 0; k < 16; k++) begin
            chk(nm, act_out(), exp_out(s, p, k));
            tick();
        end
    endtask

    task automatic chk_cnts(input string nm, input int g, input int c, input int a, input int o);
        chk({nm, "_cnts"}, {good_cnt, crc_drop_cnt, addr_drop_cnt, ovf_drop_cnt},
            {g[7:0], c[7:0], a[7:0], o[7:0]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int eg, ec, ea, eo, efc, bidx;
        logic [1:0]   qs [$];
        logic [127:0] qp [$];

        tbl[0] = '{1'b1, 2'd2, 2'd1, 2'd0, P1, C_CRC};
        tbl[1] = '{1'b0, 2'd2, 2'd3, 2'd1, P1, C_ADDR};
        tbl[2] = '{1'b0, 2'd2, 2'd2, 2'd0, P0, C_GOOD};
        tbl[3] = '{1'b1, 2'd2, 2'd2, 2'd3, P2, C_CRC};
        tbl[4] = '{1'b0, 2'd0, 2'd0, 2'd1, P1, C_GOOD};
        tbl[5] = '{1'b0, 2'd2, 2'd2, 2'd2, P2, C_GOOD};
        tbl[6] = '{1'b0, 2'd3, 2'd3, 2'd3, P3, C_GOOD};
        tbl[7] = '{1'b0, 2'd2, 2'd2, 2'd1, P4, C_OVF};
        tbl[8] = '{1'b1, 2'd0, 2'd0, 2'd2, P4, C_CRC};
        tbl[9] = '{1'b0, 2'd2, 2'd1, 2'd2, P4, C_ADDR};

        set_frame(1'b0, 2'd0, 2'd0, 2'd0, '0);
        do_reset();

        // reset state
        chk("rst_out", act_out(), 13'd0);
        chk("rst_fifo", fifo_count, 3'd0);
        chk_cnts("rst", 0, 0, 0, 0);

        // single good frame, latency and byte order
        set_frame(1'b0, 2'd2, 2'd2, 2'd1, P0);
        out_ready = 1'b1;
        pulse();
        chk("lat1_valid", out_valid, 1'b0);
        tick();
        drain_frame("single", 2'd1, P0);
        chk("single_end", {out_valid, fifo_count}, 4'd0);
        chk_cnts("single", 1, 0, 0, 0);

        // classification table with out_ready held low
        do_reset();
        eg = 0; ec = 0; ea = 0; eo = 0; efc = 0;
        for (int i = 0; i < 10; i++) begin
            set_frame(tbl[i].crc, tbl[i].my, tbl[i].dest, tbl[i].src, tbl[i].pl);
            pulse();
            tick();
            case (tbl[i].cause)
                C_GOOD: begin eg++; efc++; qs.push_back(tbl[i].src); qp.push_back(tbl[i].pl); end
                C_CRC:  ec++;
                C_ADDR: ea++;
                default: eo++;
            endcase
            chk($sformatf("tbl%0d", i), good_cnt, eg[7:0]);
            chk_cnts($sformatf("tbl%0d", i), eg, ec, ea, eo);
            chk($sformatf("tbl%0d_fifo", i), fifo_count, efc[2:0]);
            chk($sformatf("tbl%0d_valid", i), out_valid, efc > 0);
        end

        // release backpressure: 64 bytes in arrival order
        out_ready = 1'b1;
        for (int f = 0; f < 4; f++) drain_frame($sformatf("ovf_drain%0d", f), qs[f], qp[f]);
        chk("ovf_end", {out_valid, fifo_count}, 4'd0);

        // backpressure: out_ready toggles every cycle
        do_reset();
        set_frame(1'b0, 2'd1, 2'd1, 2'd2, P2);
        pulse();
        tick();
        bidx = 0;
        for (int cyc = 0; cyc < 80 && bidx < 16; cyc++) begin
            out_ready = (cyc % 2) == 1;
            chk("bp_byte", act_out(), exp_out(2'd2, P2, bidx));
            if (out_ready) bidx++;
            tick();
        end
        chk("bp_hs", bidx, 16);
        out_ready = 1'b0;
        chk("bp_end", {out_valid, fifo_count}, 4'd0);

        // full FIFO, new frame arrives on the eop handshake
        do_reset();
        qs.delete(); qp.delete();
        for (int f = 0; f < 4; f++) begin
            set_frame(1'b0, 2'd2, 2'd2, f[1:0], tbl[2+f].pl ^ {32{f[3:0]}});
            qs.push_back(f[1:0]); qp.push_back(tbl[2+f].pl ^ {32{f[3:0]}});
            pulse();
            tick();
        end
        chk("full_fifo", fifo_count, 3'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            chk("full_head", act_out(), exp_out(qs[0], qp[0], k));
            tick();
        end
        chk("full_eop", act_out(), exp_out(qs[0], qp[0], 15));
        set_frame(1'b0, 2'd2, 2'd2, 2'd3, P4);
        pulse();
        chk("pp_fifo", fifo_count, 3'd4);
        chk_cnts("pp", 5, 0, 0, 0);
        for (int f = 1; f < 4; f++) drain_frame($sformatf("pp_drain%0d", f), qs[f], qp[f]);
        drain_frame("pp_new", 2'd3, P4);
        chk("pp_end", {out_valid, fifo_count}, 4'd0);

        // reset mid-stream at idx 7
        do_reset();
        set_frame(1'b0, 2'd1, 2'd1, 2'd1, P3);
        pulse();
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        chk("mid_idx7", act_out(), exp_out(2'd1, P3, 7));
        rst = 1'b1;
        tick();
        chk("mid_rst", {out_valid, fifo_count}, 4'd0);
        chk_cnts("mid_rst", 0, 0, 0, 0);
        rst = 1'b0;
        tick(); tick();
        chk("mid_after", act_out(), 13'd0);

        // frame_valid held high across reset release and for 10 cycles
        out_ready = 1'b0;
        set_frame(1'b0, 2'd0, 2'd0, 2'd2, P1);
        rst = 1'b1; frame_valid = 1'b1;
        tick(); tick();
        chk_cnts("lvl_in_rst", 0, 0, 0, 0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk_cnts("lvl_held", 1, 0, 0, 0);
        chk("lvl_fifo", fifo_count, 3'd1);
        frame_valid = 1'b0;
        tick();
        frame_valid = 1'b1;
        tick(); tick(); tick();
        frame_valid = 1'b0;
        chk_cnts("lvl_second", 2, 0, 0, 0);

        // counter saturation
        do_reset();
        set_frame(1'b1, 2'd0, 2'd0, 2'd0, P0);
        for (int k = 0; k < 260; k++) begin
            pulse();
            tick();
        end
        chk_cnts("sat", 0, 255, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_frame_filter_fifo.md
Name: rx_frame_filter_fifo

Overview:
Downstream consumer of rx_receiver. It qualifies each received frame by CRC status and destination ID. Accepted frames (src_id plus 128-bit payload) are queued in a small frame FIFO. Queued frames are replayed as a byte stream with valid/ready handshake, and per-cause drop statistics are kept for LED/HEX display.

Parameters:
DEPTH, 4, number of frame slots in the FIFO; power of two, 2..16
CNT_W, 8, width of each saturating statistics counter

Ports:
clk  input  1  system clock (same CLK that drives rx_receiver)
rst  input  1  synchronous reset, active-high
my_id  input  2  local node ID (SW[9:8])
dest_id  input  2  destination ID from rx_receiver
src_id  input  2  source ID from rx_receiver
payload  input  128  frame payload from rx_receiver; byte 15 = [127:120]
frame_valid  input  1  frame-complete strobe from rx_receiver
crc_error  input  1  CRC failure flag, qualified by frame_valid
out_valid  output  1  byte available on out_data
out_ready  input  1  consumer accepts byte
out_data  output  8  current payload byte
out_src  output  2  src_id of the frame being streamed
out_sop  output  1  first byte of frame
out_eop  output  1  last byte of frame
fifo_count  output  log2(DEPTH)+1  frames currently queued
good_cnt  output  CNT_W  frames accepted into FIFO
crc_drop_cnt  output  CNT_W  frames dropped for CRC error
addr_drop_cnt  output  CNT_W  frames dropped for dest_id != my_id
ovf_drop_cnt  output  CNT_W  frames dropped because FIFO full

Behaviour:
- Single clock domain. All state is updated on posedge clk.
- rst=1 clears the following on the next edge: FIFO pointers and count, byte index, all counters, and the frame_valid edge register (reset value 0).
  - Output values during and after reset: out_valid=0, out_data=0, out_src=0, out_sop=0, out_eop=0, fifo_count=0.
  - Reset mid-stream discards queued frames and any partially sent frame.
- Frame event: a rising edge of frame_valid (frame_valid=1 while the previous-cycle sample was 0).
  - Exactly one classification is made per event. Holding frame_valid high produces no further events.
  - If frame_valid is held high across reset release, one event is produced on the first cycle after reset.
- Classification at the event cycle uses the inputs of that cycle. Priority order:
  1. crc_error=1 -> crc_drop_cnt+1.
  2. Else dest_id != my_id -> addr_drop_cnt+1.
  3. Else FIFO full -> ovf_drop_cnt+1.
  4. Else push {src_id, payload} and good_cnt+1.
- Full means fifo_count==DEPTH with no pop in the same cycle. A push and a pop in the same cycle are both performed, and fifo_count is unchanged.
- Counters saturate at 2^CNT_W-1 and never wrap.
- FIFO pointers wrap modulo DEPTH.
- Output stream, two states:
  - IDLE: out_valid=0. Move to SEND when fifo_count>0.
  - SEND: out_valid=1. The head frame is streamed with byte index idx 0..15, idx reset value 0.
    - out_data = head payload byte (15-idx), so MSB byte first.
    - out_sop = (idx==0).
    - out_eop = (idx==15).
    - out_src = head src_id.
  - On out_valid & out_ready:
    - If idx<15: idx+1.
    - If idx==15: pop head, idx=0. Stay in SEND if fifo_count after pop > 0, else go to IDLE.
  - out_ready=0 holds out_data, out_sop, out_eop and out_src stable.
- Latency: a frame pushed into an empty FIFO gives out_valid=1 two cycles after the frame_valid rising edge (one cycle for push, one for IDLE->SEND).
- out_data, out_src, out_sop and out_eop are 0 whenever out_valid=0.
- A push into a slot never corrupts the head frame currently being streamed, including when DEPTH frames are queued and a same-cycle pop/push occurs.

Test Plan:
- Single good frame:
  - Stimulus: my_id=2, dest_id=2, src_id=1, payload=128'h00112233_44556677_8899AABB_CCDDEEFF, one-cycle frame_valid, out_ready=1.
  - Required: out_valid after 2 cycles; bytes 00,11,...,FF over 16 cycles; sop on 00, eop on FF; out_src=1; good_cnt=1; fifo_count returns to 0.
- Drops:
  - Stimulus: frame with crc_error=1 and dest mismatch, then a frame with crc_error=0 and dest_id=3 vs my_id=2.
  - Required: crc_drop_cnt=1, addr_drop_cnt=1, good_cnt=0, out_valid stays 0.
- Overflow:
  - Stimulus: out_ready=0, 5 good frames.
  - Required: fifo_count=4, ovf_drop_cnt=1. Raising out_ready then yields exactly 64 bytes in arrival order.
- Backpressure:
  - Stimulus: toggle out_ready every cycle during a frame.
  - Required: each byte is held until accepted; 16 handshakes per frame; no byte is skipped or duplicated.
- Full plus simultaneous pop/push:
  - Stimulus: FIFO full; a good frame event arrives in the same cycle as the eop handshake.
  - Required: the frame is accepted, good_cnt+1, ovf_drop_cnt unchanged, fifo_count stays 4.
- Reset mid-stream and level-held frame_valid:
  - Stimulus: assert rst at idx=7.
  - Required: next cycle out_valid=0, fifo_count=0, all counters 0.
  - Stimulus: hold frame_valid high for 10 cycles.
  - Required: exactly one classification.
